mat_operand_loader: RTL and testbench

Upstream operand stage for the 3x3 matrix multiplier in the convolution datapath. Accepts matrix elements one per cycle over a valid/ready stream: 9 elements of A, then 9 of B, row-major. Buffers them into flat operand registers and presents both matrices together to the multiplier under a valid/ready handshake. With a build option, the B operand (the convolution kernel) can be held across multiple A loads.

---
 rtl/mat_pkg.sv | 16 +
 rtl/mat_slot_reg.sv | 37 +++
 rtl/mat_operand_loader.sv | 132 +++++++++++++
 tb/tb_mat_operand_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared packing constants and FSM encoding for the 3x3 matrix operand path.
// Used by the operand loader and the downstream multiplier.
package mat_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_N      = 3;
    localparam int ELEMS      = DEF_N * DEF_N;
    localparam int IDX_W      = $clog2(ELEMS);

endpackage

// File: rtl/mat_slot_reg.sv
// N*N-slot element register file with a single indexed write port,
// exposing all slots as one flat vector (slot k at bits [k*DATA_W +: DATA_W]).
module mat_slot_reg
    import mat_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N      = DEF_N,
    parameter int IW     = $clog2(N * N)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [IW-1:0]              idx,
    input  logic [DATA_W-1:0]          wdata,
    output logic [N*N*DATA_W-1:0]      flat
);

    logic [N*N*DATA_W-1:0] flat_q, flat_d;

    always_comb begin
        flat_d = flat_q;
        if (we) begin
            flat_d[idx*DATA_W +: DATA_W] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flat_q <= '0;
        end else begin
            flat_q <= flat_d;
        end
    end

    assign flat = flat_q;

endmodule

// File: rtl/mat_operand_loader.sv
// Streams 9 A then 9 B elements into operand registers and presents the pair.
// Build option MAT_LOADER_KEEP_B_EN adds keep_b to reuse B across A loads.
module mat_operand_loader
    import mat_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N      = DEF_N
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic [N*N*DATA_W-1:0]      a_flat,
    output logic [N*N*DATA_W-1:0]      b_flat,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef MAT_LOADER_KEEP_B_EN
    input  logic                       keep_b,
`endif
    output logic [$clog2(N*N)-1:0]     load_idx
);

    localparam int NE = N * N;
    localparam int IW = $clog2(NE);
    localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            in_ready_q, in_ready_d;
    logic            accept, last, skip_b;
    logic            we_a, we_b;

`ifdef MAT_LOADER_KEEP_B_EN
    logic keep_q, keep_d;

    // Kernel-reuse request is latched on the pair handshake.
    always_comb begin
        keep_d = keep_q;
        if (state_q == PRESENT && out_ready) begin
            keep_d = keep_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keep_q <= 1'b0;
        end else begin
            keep_q <= keep_d;
        end
    end

    assign skip_b = keep_q;
`else
    assign skip_b = 1'b0;
`endif

    assign accept = in_valid && in_ready_q;
    assign last   = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        we_a    = 1'b0;
        we_b    = 1'b0;
        unique case (state_q)
            LOAD_A: begin
                we_a = accept;
                if (accept) begin
                    idx_d = last ? '0 : idx_q + IW'(1);
                    if (last) begin
                        state_d = skip_b ? PRESENT : LOAD_B;
                    end
                end
            end
            LOAD_B: begin
                we_b = accept;
                if (accept) begin
                    idx_d = last ? '0 : idx_q + IW'(1);
                    if (last) begin
                        state_d = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    state_d = LOAD_A;
                end
            end
            default: begin
                state_d = LOAD_A;
                idx_d   = '0;
            end
        endcase
        in_ready_d = (state_d != PRESENT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD_A;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            in_ready_q <= in_ready_d;
        end
    end

    mat_slot_reg #(.DATA_W(DATA_W), .N(N), .IW(IW)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_a),
        .idx   (idx_q),
        .wdata (in_data),
        .flat  (a_flat)
    );

    mat_slot_reg #(.DATA_W(DATA_W), .N(N), .IW(IW)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_b),
        .idx   (idx_q),
        .wdata (in_data),
        .flat  (b_flat)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == PRESENT);
    assign load_idx  = idx_q;

endmodule

// File: tb/tb_mat_operand_loader.sv
// Scoreboard bench for mat_operand_loader: a beat-level model predicts each
// operand pair; a negedge monitor compares whatever the DUT presents.
module tb_mat_operand_loader;

    localparam int FW = 72;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = '0;
    logic [FW-1:0] a_flat, b_flat;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          keep_b = 1'b0;
    logic [3:0]    load_idx;

    mat_operand_loader #(.DATA_W(8), .N(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef MAT_LOADER_KEEP_B_EN
        .keep_b    (keep_b),
`endif
        .load_idx  (load_idx)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0]    a_m [9];
    logic [7:0]    b_m [9];
    int            cnt = 0;
    bit            pres = 0;
    bit            fresh = 0;
    bit            keep_flag = 0;
    logic [FW-1:0] qa [$];
    logic [FW-1:0] qb [$];

    task automatic chk(input string nm, input logic [FW-1:0] act,
                       input logic [FW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic push_pair();
        logic [FW-1:0] ea, eb;
        for (int k = 0; k < 9; k++) begin
            ea[k*8 +: 8] = a_m[k];
            eb[k*8 +: 8] = b_m[k];
        end
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    // One clock: apply inputs, check control outputs at negedge, then
    // advance the model at the rising edge.
    task automatic cyc(input bit iv, input logic [7:0] d, input bit ordy,
                       input bit kb);
        int len;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        keep_b    = kb;
        @(negedge clk);
        chk("in_ready", FW'(in_ready), FW'(!pres && !fresh));
        chk("out_valid", FW'(out_valid), FW'(pres));
        chk("load_idx", FW'(load_idx), pres ? '0 : FW'(cnt % 9));
        @(posedge clk);
        len = keep_flag ? 9 : 18;
        if (fresh) begin
            fresh = 0;
        end else if (pres) begin
            if (ordy) begin
                pres = 0;
                cnt  = 0;
`ifdef MAT_LOADER_KEEP_B_EN
                keep_flag = kb;
`endif
            end
        end else if (iv) begin
            if (cnt < 9) a_m[cnt] = d;
            else b_m[cnt-9] = d;
            cnt++;
            if (cnt == len) begin
                pres = 1;
                push_pair();
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", FW'(out_valid), '0);
        chk("rst_in_ready", FW'(in_ready), '0);
        chk("rst_load_idx", FW'(load_idx), '0);
        chk("rst_a_flat", a_flat, '0);
        chk("rst_b_flat", b_flat, '0);
        for (int k = 0; k < 9; k++) begin
            a_m[k] = '0;
            b_m[k] = '0;
        end
        cnt = 0; pres = 0; keep_flag = 0;
        qa.delete();
        qb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fresh = 1;
    endtask

    task automatic fill();
        int guard = 0;
        while (!pres && guard < 100) begin
            cyc($urandom_range(3, 0) != 0, 8'($urandom), 1'b0, 1'b0);
            guard++;
        end
        if (!pres) chk("fill_timeout", '0, 1);
    endtask

    task automatic drain();
        int guard = 0;
        while (pres && guard < 100) begin
            cyc($urandom_range(1, 0) != 0, 8'($urandom),
                $urandom_range(2, 0) == 0, 1'b0);
            guard++;
        end
        if (pres) chk("drain_timeout", '0, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (qa.size() == 0) begin
                chk("pair_expected", '0, 1);
            end else begin
                chk("a_flat", a_flat, qa[0]);
                chk("b_flat", b_flat, qb[0]);
                if (out_ready) begin
                    void'(qa.pop_front());
                    void'(qb.pop_front());
                end
            end
        end
    end

    initial begin
        do_reset();
        // Sequential stream, then a held presentation with in_valid noise
        for (int k = 0; k < 18; k++) cyc(1'b1, 8'(k), 1'b0, 1'b0);
        repeat (5) cyc(1'b1, 8'd99, 1'b0, 1'b0);
        cyc(1'b1, 8'd99, 1'b1, 1'b0);
        cyc(1'b0, 8'd0, 1'b0, 1'b0);
        // Gapped stream
        for (int k = 1; k <= 18; k++) begin
            cyc(1'b1, 8'(k), 1'b0, 1'b0);
            cyc(1'b0, 8'd0, 1'b1, 1'b0);
        end
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        // Kernel reuse request, then a full reload
        for (int k = 0; k < 18; k++) cyc(1'b1, 8'(k), 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 1'b1);
        for (int k = 20; k < 29; k++) cyc(1'b1, 8'(k), 1'b0, 1'b0);
        fill();
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        fill();
        drain();
        // Reset in the middle of an A load
        for (int k = 0; k < 5; k++) cyc(1'b1, 8'(40 + k), 1'b0, 1'b0);
        do_reset();
        for (int k = 0; k < 18; k++) cyc(1'b1, 8'(50 + k), 1'b0, 1'b0);
        drain();
        // Maximum element values
        for (int k = 0; k < 18; k++) cyc(1'b1, 8'd255, 1'b0, 1'b0);
        drain();
        // Random traffic
        repeat (600) cyc($urandom_range(3, 0) != 0, 8'($urandom),
                         $urandom_range(2, 0) == 0, 1'($urandom));
        drain();
        chk("queue_empty", FW'(qa.size()), '0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
